sensor_frame_rx: RTL



---
 rtl/sensor_link_pkg.sv | 20 ++
 rtl/uart_rx_byte.sv | 81 ++++++++
 rtl/sensor_frame_rx.sv | 114 +++++++++++
 3 files changed

// File: rtl/sensor_link_pkg.sv
// Shared constants, state encodings and small helpers for the Pico -> FPGA sensor link.
package sensor_link_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] HUM_MAX   = 8'd63;
  localparam logic [7:0] MOI_MAX   = 8'd7;
  localparam logic [7:0] ERR_MAX   = 8'hFF;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {P_SYNC, P_HUM, P_MOI, P_CK} parse_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

  function automatic logic [5:0] clamp_hum(input logic [7:0] h);
    return (h > HUM_MAX) ? HUM_MAX[5:0] : h[5:0];
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle done/error strobes.
module uart_rx_byte
  import sensor_link_pkg::*;
#(
  parameter int unsigned BIT_DIV = 434
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       rx_in,
  output logic       byte_done,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam logic [15:0] DIV_LAST  = 16'(BIT_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BIT_DIV / 2 - 1);

  logic [1:0]  sync_q;
  logic        rx_s;
  rx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk50) begin
    if (reset) begin
      sync_q    <= 2'b11;
      state_q   <= R_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data      <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        R_IDLE: begin
          if (!rx_s) begin
            state_q <= R_START;
            cnt_q   <= '0;
          end
        end
        R_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= '0;
            // A start bit that is high again at mid-bit is a glitch, not an error.
            state_q <= rx_s ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        R_DATA: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            data  <= {rx_s, data[7:1]};
            if (bit_q == 3'd7) state_q <= R_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        R_STOP: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q     <= '0;
            byte_done <= rx_s;
            frame_err <= !rx_s;
            state_q   <= R_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sensor_frame_rx.sv
// Checked serial sensor link: parses A5/H/M/CK frames into humidity and moisture registers.
// Optional stale-link timer enabled by defining SENSOR_STALE_TIMEOUT_EN.
module sensor_frame_rx
  import sensor_link_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned STALE_MS = 2000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       rx_in,
  output logic [5:0] humidity,
  output logic [2:0] moisture,
  output logic       frame_valid,
  output logic       stale,
  output logic [7:0] err_count
);

  localparam int unsigned BIT_DIV = CLK_HZ / BAUD;

  if (BIT_DIV < 4 || STALE_MS == 0) begin : g_cfg_check
    $error("sensor_frame_rx: BIT_DIV must be >= 4 and STALE_MS nonzero");
  end

  logic         byte_done;
  logic         frame_err;
  logic [7:0]   data;
  parse_state_e pstate;
  logic [7:0]   hum_q;
  logic [7:0]   moi_q;
  logic         ck_ok;
  logic         accept;

  uart_rx_byte #(
    .BIT_DIV (BIT_DIV)
  ) u_rx (
    .clk50     (clk50),
    .reset     (reset),
    .rx_in     (rx_in),
    .byte_done (byte_done),
    .data      (data),
    .frame_err (frame_err)
  );

  always_comb begin
    ck_ok  = (data == (SYNC_BYTE ^ hum_q ^ moi_q)) && (moi_q <= MOI_MAX);
    accept = byte_done && (pstate == P_CK) && ck_ok;
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      pstate      <= P_SYNC;
      hum_q       <= '0;
      moi_q       <= '0;
      humidity    <= '0;
      moisture    <= '0;
      frame_valid <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      // The receiver never raises frame_err and byte_done together, so one bump per byte.
      if (frame_err) begin
        pstate    <= P_SYNC;
        err_count <= sat_inc(err_count);
      end else if (byte_done) begin
        unique case (pstate)
          P_SYNC: if (data == SYNC_BYTE) pstate <= P_HUM;
          P_HUM: begin
            hum_q  <= data;
            pstate <= P_MOI;
          end
          P_MOI: begin
            moi_q  <= data;
            pstate <= P_CK;
          end
          P_CK: begin
            pstate <= P_SYNC;
            if (accept) begin
              humidity    <= clamp_hum(hum_q);
              moisture    <= moi_q[2:0];
              frame_valid <= 1'b1;
            end else begin
              err_count <= sat_inc(err_count);
            end
          end
          default: pstate <= P_SYNC;
        endcase
      end
    end
  end

`ifdef SENSOR_STALE_TIMEOUT_EN
  localparam int unsigned STALE_CYCLES = (CLK_HZ / 1000) * STALE_MS;

  logic [31:0] stale_cnt;

  always_ff @(posedge clk50) begin
    if (reset) begin
      stale_cnt <= '0;
      stale     <= 1'b1;
    end else if (accept) begin
      stale_cnt <= '0;
      stale     <= 1'b0;
    end else if (stale_cnt != STALE_CYCLES) begin
      stale_cnt <= stale_cnt + 32'd1;
      if (stale_cnt + 32'd1 == STALE_CYCLES) stale <= 1'b1;
    end
  end
`else
  assign stale = 1'b0;
`endif

endmodule
